// File: rtl/led_chaser.sv
// ---------------------------------------------------------------------------
// led_chaser
//   Parametrised LED running-light generator. A prescaler divides CLK down to
//   a one-cycle step tick; on each tick the LED pattern advances according to
//   the captured run mode (rotate-left, rotate-right, ping-pong, bar-fill).
//   A change of MODE seen on a tick reloads the pattern instead of advancing.
//
// Ports
//   CLK        : system clock, rising-edge active
//   RST_N      : asynchronous active-low reset
//   EN         : 1 = run, 0 = freeze prescaler and pattern
//   MODE       : 00 rotate-left, 01 rotate-right, 10 ping-pong, 11 bar-fill
//   LED_OUT    : LED drive (1 = lit), registered
//   STEP_PULSE : one-cycle strobe while LED_OUT holds a freshly stepped value
// ---------------------------------------------------------------------------
module led_chaser #(
  parameter int LED_NUM  = 8,
  parameter int TICK_CNT = 5_000_000,
  parameter int CNT_W    = 23
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               EN,
  input  logic [1:0]         MODE,
  output logic [LED_NUM-1:0] LED_OUT,
  output logic               STEP_PULSE
);

  typedef enum logic [1:0] {
    MODE_ROL  = 2'b00,
    MODE_ROR  = 2'b01,
    MODE_PING = 2'b10,
    MODE_BAR  = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam logic [CNT_W-1:0]   TICK_LAST = CNT_W'(TICK_CNT - 1);
  localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1'b1);
  localparam logic [LED_NUM-1:0] LED_NONE  = {LED_NUM{1'b0}};
  localparam logic [LED_NUM-1:0] LED_ALL   = {LED_NUM{1'b1}};
  localparam logic [LED_NUM-1:0] LED_LSB   = {{(LED_NUM-1){1'b0}}, 1'b1};
  localparam logic [LED_NUM-1:0] LED_MSB   = {1'b1, {(LED_NUM-1){1'b0}}};

  // True when exactly one LED is lit; clearing the lowest set bit must leave zero.
  function automatic logic is_onehot(input logic [LED_NUM-1:0] v);
    logic [LED_NUM-1:0] low_cleared;
    low_cleared = v & (v - LED_LSB);
    return (v != LED_NONE) && (low_cleared == LED_NONE);
  endfunction

  logic [CNT_W-1:0]   cnt_r;
  logic [LED_NUM-1:0] led_r;
  dir_t               dir_r;
  mode_t              cur_mode_r;
  logic               step_pulse_r;

  logic               tick_s;
  mode_t              mode_in_s;
  logic [LED_NUM-1:0] led_nxt_s;
  dir_t               dir_nxt_s;
  mode_t              mode_nxt_s;
  logic [LED_NUM-1:0] rol_s;
  logic [LED_NUM-1:0] ror_s;
  logic [LED_NUM-1:0] shl_s;
  logic [LED_NUM-1:0] shr_s;
  logic [LED_NUM-1:0] fill_s;

  // The step tick is suppressed whenever EN is low, even at the terminal count.
  assign tick_s    = EN && (cnt_r == TICK_LAST);
  assign mode_in_s = mode_t'(MODE);

  assign rol_s  = {led_r[LED_NUM-2:0], led_r[LED_NUM-1]};
  assign ror_s  = {led_r[0], led_r[LED_NUM-1:1]};
  assign shl_s  = {led_r[LED_NUM-2:0], 1'b0};
  assign shr_s  = {1'b0, led_r[LED_NUM-1:1]};
  assign fill_s = {led_r[LED_NUM-2:0], 1'b1};

  // Prescaler: counts 0..TICK_CNT-1 while enabled, holds its value while disabled.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_r <= CNT_ZERO;
    end else if (EN) begin
      if (cnt_r == TICK_LAST) begin
        cnt_r <= CNT_ZERO;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Next pattern, direction and mode for the coming tick (only used on a tick).
  always_comb begin
    led_nxt_s  = led_r;
    dir_nxt_s  = dir_r;
    mode_nxt_s = cur_mode_r;
    if (mode_in_s != cur_mode_r) begin
      // Reload step: a ping-pong direction flip on this tick is deliberately dropped.
      mode_nxt_s = mode_in_s;
      dir_nxt_s  = DIR_UP;
      case (mode_in_s)
        MODE_ROR: led_nxt_s = LED_MSB;
        default:  led_nxt_s = LED_LSB;
      endcase
    end else begin
      case (cur_mode_r)
        MODE_ROL: begin
          if (!is_onehot(led_r)) begin
            led_nxt_s = LED_LSB;
            dir_nxt_s = DIR_UP;
          end else begin
            led_nxt_s = rol_s;
          end
        end
        MODE_ROR: begin
          if (!is_onehot(led_r)) begin
            led_nxt_s = LED_LSB;
            dir_nxt_s = DIR_UP;
          end else begin
            led_nxt_s = ror_s;
          end
        end
        MODE_PING: begin
          if (!is_onehot(led_r)) begin
            led_nxt_s = LED_LSB;
            dir_nxt_s = DIR_UP;
          end else if (dir_r == DIR_UP) begin
            // Turning around on the same edge keeps each end lit for one step.
            led_nxt_s = shl_s;
            if (shl_s[LED_NUM-1]) begin
              dir_nxt_s = DIR_DOWN;
            end else begin
              dir_nxt_s = DIR_UP;
            end
          end else begin
            led_nxt_s = shr_s;
            if (shr_s[0]) begin
              dir_nxt_s = DIR_UP;
            end else begin
              dir_nxt_s = DIR_DOWN;
            end
          end
        end
        MODE_BAR: begin
          if (led_r == LED_ALL) begin
            led_nxt_s = LED_NONE;
          end else if (led_r == LED_NONE) begin
            led_nxt_s = LED_LSB;
          end else begin
            led_nxt_s = fill_s;
          end
        end
        default: begin
          led_nxt_s = LED_LSB;
          dir_nxt_s = DIR_UP;
        end
      endcase
    end
  end

  // Pattern state: updated only on the step tick.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      led_r      <= LED_LSB;
      dir_r      <= DIR_UP;
      cur_mode_r <= MODE_ROL;
    end else if (tick_s) begin
      led_r      <= led_nxt_s;
      dir_r      <= dir_nxt_s;
      cur_mode_r <= mode_nxt_s;
    end else begin
      led_r      <= led_r;
      dir_r      <= dir_r;
      cur_mode_r <= cur_mode_r;
    end
  end

  // Step strobe: high in the cycle after each tick, aligned with the new LED value.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      step_pulse_r <= 1'b0;
    end else begin
      step_pulse_r <= tick_s;
    end
  end

  assign LED_OUT    = led_r;
  assign STEP_PULSE = step_pulse_r;

endmodule

// File: tb/tb_led_chaser.sv
// ---------------------------------------------------------------------------
// tb_led_chaser
//   Directed bench for led_chaser with LED_NUM=4, TICK_CNT=4, CNT_W=2.
//   Inputs change on the falling edge; outputs are sampled on the falling edge.
//   With reset released on a falling edge, a step lands on every 4th rising
//   edge, so STEP_PULSE is seen high on every 4th falling edge.
// ---------------------------------------------------------------------------
module tb_led_chaser;

  logic       CLK;
  logic       RST_N;
  logic       EN;
  logic [1:0] MODE;
  logic [3:0] LED_OUT;
  logic       STEP_PULSE;

  int checks;
  int failures;

  led_chaser #(
    .LED_NUM  (4),
    .TICK_CNT (4),
    .CNT_W    (2)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .EN         (EN),
    .MODE       (MODE),
    .LED_OUT    (LED_OUT),
    .STEP_PULSE (STEP_PULSE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Hard stop in case anything stalls.
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset(input logic [1:0] m);
    RST_N = 1'b0;
    EN    = 1'b1;
    MODE  = m;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    EN    = 1'b1;
    MODE  = 2'b00;
    repeat (2) @(negedge CLK);
    checks++;
    if (LED_OUT !== 4'b0001) begin
      failures++;
      $display("FAIL reset_led got=%b exp=0001", LED_OUT);
    end
    checks++;
    if (STEP_PULSE !== 1'b0) begin
      failures++;
      $display("FAIL reset_pulse got=%b exp=0", STEP_PULSE);
    end
    RST_N = 1'b1;
  endtask

  task automatic test_rotate_left();
    logic [3:0] exp_seq [4];
    logic [3:0] prev;
    exp_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    apply_reset(2'b00);
    prev = 4'b0001;
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge CLK);
        checks++;
        if (STEP_PULSE !== (k == 3)) begin
          failures++;
          $display("FAIL rol_pulse step=%0d cyc=%0d got=%b exp=%b", s, k, STEP_PULSE, (k == 3));
        end
        checks++;
        if (LED_OUT !== ((k == 3) ? exp_seq[s] : prev)) begin
          failures++;
          $display("FAIL rol_led step=%0d cyc=%0d got=%b exp=%b", s, k, LED_OUT, ((k == 3) ? exp_seq[s] : prev));
        end
      end
      prev = exp_seq[s];
    end
  endtask

  task automatic test_ping_pong();
    logic [3:0] exp_seq [8];
    // First step is a reload because the mode after reset is 00.
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    apply_reset(2'b10);
    for (int s = 0; s < 8; s++) begin
      repeat (3) @(negedge CLK);
      @(negedge CLK);
      checks++;
      if (STEP_PULSE !== 1'b1 || LED_OUT !== exp_seq[s]) begin
        failures++;
        $display("FAIL ping_step step=%0d got led=%b pulse=%b exp led=%b pulse=1", s, LED_OUT, STEP_PULSE, exp_seq[s]);
      end
    end
  endtask

  task automatic test_mode_switch();
    logic [3:0] exp_seq [4];
    exp_seq = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
    apply_reset(2'b00);
    repeat (8) @(negedge CLK);
    checks++;
    if (LED_OUT !== 4'b0100) begin
      failures++;
      $display("FAIL sw_pre got=%b exp=0100", LED_OUT);
    end
    repeat (2) @(negedge CLK);
    MODE = 2'b01;
    @(negedge CLK);
    checks++;
    if (LED_OUT !== 4'b0100 || STEP_PULSE !== 1'b0) begin
      failures++;
      $display("FAIL sw_hold got led=%b pulse=%b exp led=0100 pulse=0", LED_OUT, STEP_PULSE);
    end
    @(negedge CLK);
    checks++;
    if (LED_OUT !== 4'b1000 || STEP_PULSE !== 1'b1) begin
      failures++;
      $display("FAIL sw_reload got led=%b pulse=%b exp led=1000 pulse=1", LED_OUT, STEP_PULSE);
    end
    for (int s = 0; s < 4; s++) begin
      repeat (4) @(negedge CLK);
      checks++;
      if (LED_OUT !== exp_seq[s] || STEP_PULSE !== 1'b1) begin
        failures++;
        $display("FAIL sw_ror step=%0d got led=%b pulse=%b exp led=%b pulse=1", s, LED_OUT, STEP_PULSE, exp_seq[s]);
      end
    end
  endtask

  task automatic test_bar_fill();
    logic [3:0] exp_seq [7];
    exp_seq = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0000, 4'b0001, 4'b0011};
    apply_reset(2'b11);
    for (int s = 0; s < 7; s++) begin
      repeat (4) @(negedge CLK);
      checks++;
      if (LED_OUT !== exp_seq[s] || STEP_PULSE !== 1'b1) begin
        failures++;
        $display("FAIL bar_step step=%0d got led=%b pulse=%b exp led=%b pulse=1", s, LED_OUT, STEP_PULSE, exp_seq[s]);
      end
    end
  endtask

  task automatic test_enable_freeze();
    apply_reset(2'b00);
    repeat (2) @(negedge CLK);
    EN = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      checks++;
      if (LED_OUT !== 4'b0001 || STEP_PULSE !== 1'b0) begin
        failures++;
        $display("FAIL en_frozen cyc=%0d got led=%b pulse=%b exp led=0001 pulse=0", k, LED_OUT, STEP_PULSE);
      end
    end
    EN = 1'b1;
    @(negedge CLK);
    checks++;
    if (LED_OUT !== 4'b0001 || STEP_PULSE !== 1'b0) begin
      failures++;
      $display("FAIL en_resume1 got led=%b pulse=%b exp led=0001 pulse=0", LED_OUT, STEP_PULSE);
    end
    @(negedge CLK);
    checks++;
    if (LED_OUT !== 4'b0010 || STEP_PULSE !== 1'b1) begin
      failures++;
      $display("FAIL en_resume2 got led=%b pulse=%b exp led=0010 pulse=1", LED_OUT, STEP_PULSE);
    end
  endtask

  task automatic test_en_tick_collision();
    apply_reset(2'b00);
    repeat (3) @(negedge CLK);
    // Counter now sits at the terminal count; dropping EN must kill the tick.
    EN = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      checks++;
      if (LED_OUT !== 4'b0001 || STEP_PULSE !== 1'b0) begin
        failures++;
        $display("FAIL coll_frozen cyc=%0d got led=%b pulse=%b exp led=0001 pulse=0", k, LED_OUT, STEP_PULSE);
      end
    end
    EN = 1'b1;
    @(negedge CLK);
    checks++;
    if (LED_OUT !== 4'b0010 || STEP_PULSE !== 1'b1) begin
      failures++;
      $display("FAIL coll_resume got led=%b pulse=%b exp led=0010 pulse=1", LED_OUT, STEP_PULSE);
    end
  endtask

  task automatic test_async_reset();
    apply_reset(2'b10);
    // Steps: reload 0001, 0010, 0100, 1000, then 0100 heading down.
    repeat (20) @(negedge CLK);
    checks++;
    if (LED_OUT !== 4'b0100 || STEP_PULSE !== 1'b1) begin
      failures++;
      $display("FAIL ar_pre got led=%b pulse=%b exp led=0100 pulse=1", LED_OUT, STEP_PULSE);
    end
    #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if (LED_OUT !== 4'b0001 || STEP_PULSE !== 1'b0) begin
      failures++;
      $display("FAIL ar_immediate got led=%b pulse=%b exp led=0001 pulse=0", LED_OUT, STEP_PULSE);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (4) @(negedge CLK);
    checks++;
    if (LED_OUT !== 4'b0001 || STEP_PULSE !== 1'b1) begin
      failures++;
      $display("FAIL ar_reload got led=%b pulse=%b exp led=0001 pulse=1", LED_OUT, STEP_PULSE);
    end
    repeat (4) @(negedge CLK);
    checks++;
    if (LED_OUT !== 4'b0010 || STEP_PULSE !== 1'b1) begin
      failures++;
      $display("FAIL ar_first_adv got led=%b pulse=%b exp led=0010 pulse=1", LED_OUT, STEP_PULSE);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RST_N    = 1'b0;
    EN       = 1'b0;
    MODE     = 2'b00;
    test_reset();
    test_rotate_left();
    test_ping_pong();
    test_mode_switch();
    test_bar_fill();
    test_enable_freeze();
    test_en_tick_collision();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
